id_ex_pipe_reg: RTL and testbench



---
 rtl/id_ex_pipe_reg.sv | 109 ++++++++++
 tb/tb_id_ex_pipe_reg.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: decode fields, valid bit, stall/flush control and saturating bubble/stall counters.
// Latency: one clk1 cycle from inputs to outputs; every output comes straight from a flop.
// Backpressure: stall holds the register and does not sample inputs; flush overrides stall.
module id_ex_pipe_reg #(
    parameter int REG_AW  = 3,
    parameter int DATA_W  = 8,
    parameter int ALUFN_W = 1,
    parameter int CNT_W   = 8
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [REG_AW-1:0]    ra_in,
    input  logic [REG_AW-1:0]    rb_in,
    input  logic [REG_AW-1:0]    rd_in,
    input  logic [DATA_W-1:0]    imm_in,
    input  logic [DATA_W-1:0]    m1_in,
    input  logic [DATA_W-1:0]    m2_in,
    input  logic [5+ALUFN_W:0]   ctrl_in,
    output logic                 out_valid,
    output logic [REG_AW-1:0]    ra_out,
    output logic [REG_AW-1:0]    rb_out,
    output logic [REG_AW-1:0]    rd_out,
    output logic [DATA_W-1:0]    imm_out,
    output logic [DATA_W-1:0]    m1_out,
    output logic [DATA_W-1:0]    m2_out,
    output logic [5+ALUFN_W:0]   ctrl_out,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int CTRL_W = 6 + ALUFN_W;

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] m1;
        logic [DATA_W-1:0] m2;
        logic [CTRL_W-1:0] ctrl;
    } idex_t;

    idex_t stage_q;
    idex_t stage_d;
    logic  bubble_evt;
    logic  stall_evt;

    // A bubble is an all-zero entry, so ctrl can never be non-zero without vld.
    always_comb begin
        stage_d    = stage_q;
        bubble_evt = 1'b0;
        stall_evt  = 1'b0;
        if (flush) begin
            stage_d    = '0;
            bubble_evt = 1'b1;
        end else if (stall) begin
            stall_evt  = 1'b1;
        end else if (in_valid) begin
            stage_d.vld  = 1'b1;
            stage_d.ra   = ra_in;
            stage_d.rb   = rb_in;
            stage_d.rd   = rd_in;
            stage_d.imm  = imm_in;
            stage_d.m1   = m1_in;
            stage_d.m2   = m2_in;
            stage_d.ctrl = ctrl_in;
        end else begin
            stage_d    = '0;
            bubble_evt = 1'b1;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Statistics counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk1) begin
        if (rst) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (bubble_evt && (bubble_cnt != {CNT_W{1'b1}})) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = stage_q.vld;
    assign ra_out    = stage_q.ra;
    assign rb_out    = stage_q.rb;
    assign rd_out    = stage_q.rd;
    assign imm_out   = stage_q.imm;
    assign m1_out    = stage_q.m1;
    assign m2_out    = stage_q.m2;
    assign ctrl_out  = stage_q.ctrl;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: default, narrow-counter and wide-field instances.
module tb_id_ex_pipe_reg;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Default-parameter instance
    logic       rst, stall, flush, in_valid;
    logic [2:0] ra, rb, rd;
    logic [7:0] imm, m1, m2;
    logic [6:0] ctrl;
    logic       out_valid;
    logic [2:0] ra_out, rb_out, rd_out;
    logic [7:0] imm_out, m1_out, m2_out;
    logic [6:0] ctrl_out;
    logic [7:0] bubble_cnt, stall_cnt;

    id_ex_pipe_reg dut (
        .clk1(clk1), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .ra_in(ra), .rb_in(rb), .rd_in(rd), .imm_in(imm), .m1_in(m1), .m2_in(m2), .ctrl_in(ctrl),
        .out_valid(out_valid), .ra_out(ra_out), .rb_out(rb_out), .rd_out(rd_out),
        .imm_out(imm_out), .m1_out(m1_out), .m2_out(m2_out), .ctrl_out(ctrl_out),
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    // CNT_W=4 instance for saturation
    logic       s_rst, s_stall, s_flush, s_in_valid;
    logic       s_out_valid;
    logic [2:0] s_ra_out, s_rb_out, s_rd_out;
    logic [7:0] s_imm_out, s_m1_out, s_m2_out;
    logic [6:0] s_ctrl_out;
    logic [3:0] s_bubble_cnt, s_stall_cnt;

    id_ex_pipe_reg #(.CNT_W(4)) dut_s (
        .clk1(clk1), .rst(s_rst), .stall(s_stall), .flush(s_flush), .in_valid(s_in_valid),
        .ra_in(3'd1), .rb_in(3'd2), .rd_in(3'd3), .imm_in(8'h5A), .m1_in(8'hA5), .m2_in(8'h3C),
        .ctrl_in(7'h55),
        .out_valid(s_out_valid), .ra_out(s_ra_out), .rb_out(s_rb_out), .rd_out(s_rd_out),
        .imm_out(s_imm_out), .m1_out(s_m1_out), .m2_out(s_m2_out), .ctrl_out(s_ctrl_out),
        .bubble_cnt(s_bubble_cnt), .stall_cnt(s_stall_cnt)
    );

    // Wide-field instance
    logic        w_rst, w_stall, w_flush, w_in_valid;
    logic [4:0]  w_ra, w_rb, w_rd;
    logic [15:0] w_imm, w_m1, w_m2;
    logic [8:0]  w_ctrl;
    logic        w_out_valid;
    logic [4:0]  w_ra_out, w_rb_out, w_rd_out;
    logic [15:0] w_imm_out, w_m1_out, w_m2_out;
    logic [8:0]  w_ctrl_out;
    logic [7:0]  w_bubble_cnt, w_stall_cnt;

    id_ex_pipe_reg #(.REG_AW(5), .DATA_W(16), .ALUFN_W(3)) dut_w (
        .clk1(clk1), .rst(w_rst), .stall(w_stall), .flush(w_flush), .in_valid(w_in_valid),
        .ra_in(w_ra), .rb_in(w_rb), .rd_in(w_rd), .imm_in(w_imm), .m1_in(w_m1), .m2_in(w_m2),
        .ctrl_in(w_ctrl),
        .out_valid(w_out_valid), .ra_out(w_ra_out), .rb_out(w_rb_out), .rd_out(w_rd_out),
        .imm_out(w_imm_out), .m1_out(w_m1_out), .m2_out(w_m2_out), .ctrl_out(w_ctrl_out),
        .bubble_cnt(w_bubble_cnt), .stall_cnt(w_stall_cnt)
    );

    // Reference model: expected register contents and event counts for the default instance
    logic [40:0] exp_fields;
    int          exp_bub;
    int          exp_stl;
    wire  [40:0] act_fields = {out_valid, ra_out, rb_out, rd_out, imm_out, m1_out, m2_out, ctrl_out};

    task automatic model_edge();
        if (rst) begin
            exp_fields = '0;
            exp_bub    = 0;
            exp_stl    = 0;
        end else if (flush || (!stall && !in_valid)) begin
            exp_fields = '0;
            exp_bub    = (exp_bub < 255) ? exp_bub + 1 : 255;
        end else if (stall) begin
            exp_stl    = (exp_stl < 255) ? exp_stl + 1 : 255;
        end else begin
            exp_fields = {1'b1, ra, rb, rd, imm, m1, m2, ctrl};
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        model_edge();
        @(negedge clk1);
    endtask

    task automatic rand_fields();
        ra   = 3'($urandom);
        rb   = 3'($urandom);
        rd   = 3'($urandom);
        imm  = 8'($urandom);
        m1   = 8'($urandom);
        m2   = 8'($urandom);
        ctrl = 7'($urandom);
    endtask

    // Control-gating invariant on every instance
    always @(negedge clk1) begin
        n_tests++;
        if ((out_valid === 1'b0 && ctrl_out !== 7'd0) ||
            (s_out_valid === 1'b0 && s_ctrl_out !== 7'd0) ||
            (w_out_valid === 1'b0 && w_ctrl_out !== 9'd0)) begin
            n_fail++;
            $display("FAIL ctrl_gating: ctrl=%h/%h/%h with valid=%b/%b/%b, required ctrl=0 when invalid",
                     ctrl_out, s_ctrl_out, w_ctrl_out, out_valid, s_out_valid, w_out_valid);
        end
    end

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
        rand_fields();
        ctrl = 7'h7F;
        repeat (2) begin
            tick();
            n_tests++;
            if (act_fields !== 41'd0 || bubble_cnt !== 8'd0 || stall_cnt !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_state: fields=%h bub=%0d stl=%0d, required all 0",
                         act_fields, bubble_cnt, stall_cnt);
            end
        end
        rst = 1'b0;
        ra = 3'd3; rb = 3'd5; rd = 3'd7; imm = 8'hF4; m1 = 8'h12; m2 = 8'h34; ctrl = 7'h7F;
        tick();
        n_tests++;
        if (act_fields !== {1'b1, 3'd3, 3'd5, 3'd7, 8'hF4, 8'h12, 8'h34, 7'h7F}) begin
            n_fail++;
            $display("FAIL first_load: got %h, required %h", act_fields,
                     {1'b1, 3'd3, 3'd5, 3'd7, 8'hF4, 8'h12, 8'h34, 7'h7F});
        end
    endtask

    task automatic test_stall_hold();
        rand_fields(); imm = 8'h11; in_valid = 1'b1;
        tick();
        stall = 1'b1;
        rand_fields(); imm = 8'h22;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (imm_out !== 8'h11 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: imm=%h valid=%b, required imm=11 valid=1", i, imm_out, out_valid);
            end
        end
        n_tests++;
        if (stall_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL stall_count: got %0d, required 3", stall_cnt);
        end
        stall = 1'b0;
        tick();
        n_tests++;
        if (imm_out !== 8'h22 || act_fields !== exp_fields) begin
            n_fail++;
            $display("FAIL stall_release: got %h, required %h (imm 22)", act_fields, exp_fields);
        end
    endtask

    task automatic test_flush_priority();
        stall = 1'b1; flush = 1'b1; in_valid = 1'b1; ctrl = 7'h7F;
        tick();
        stall = 1'b0; flush = 1'b0;
        n_tests++;
        if (act_fields !== 41'd0 || bubble_cnt !== 8'd1 || stall_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL flush_priority: fields=%h bub=%0d stl=%0d, required 0/1/3",
                     act_fields, bubble_cnt, stall_cnt);
        end
    endtask

    task automatic test_idle_bubbles();
        rst = 1'b1; tick(); rst = 1'b0;
        in_valid = 1'b0; rand_fields(); ctrl = 7'h7F;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b0 || ctrl_out !== 7'd0) begin
                n_fail++;
                $display("FAIL idle_bubble[%0d]: valid=%b ctrl=%h, required 0/0", i, out_valid, ctrl_out);
            end
        end
        n_tests++;
        if (bubble_cnt !== 8'd5 || stall_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL idle_count: bub=%0d stl=%0d, required 5/0", bubble_cnt, stall_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; rand_fields(); ctrl = 7'h7F;
        tick();
        rst = 1'b1; stall = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        n_tests++;
        if (act_fields !== 41'd0 || bubble_cnt !== 8'd0 || stall_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_midstream: fields=%h bub=%0d stl=%0d, required all 0",
                     act_fields, bubble_cnt, stall_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 700; i++) begin
            rst      = ($urandom_range(199, 0) == 0);
            flush    = ($urandom_range(99, 0) < 12);
            stall    = ($urandom_range(99, 0) < 35);
            in_valid = ($urandom_range(99, 0) < 60);
            rand_fields();
            tick();
            n_tests++;
            if (act_fields !== exp_fields || bubble_cnt !== 8'(exp_bub) || stall_cnt !== 8'(exp_stl)) begin
                n_fail++;
                $display("FAIL random[%0d]: fields=%h bub=%0d stl=%0d, required %h/%0d/%0d",
                         i, act_fields, bubble_cnt, stall_cnt, exp_fields, exp_bub, exp_stl);
            end
        end
        rst = 1'b0; flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_saturation();
        s_rst = 1'b0; s_stall = 1'b1; s_in_valid = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk1); @(negedge clk1);
            n_tests++;
            if (s_stall_cnt !== 4'((i < 15) ? i : 15)) begin
                n_fail++;
                $display("FAIL stall_sat[%0d]: got %0d, required %0d", i, s_stall_cnt, (i < 15) ? i : 15);
            end
        end
        s_stall = 1'b0; s_in_valid = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk1); @(negedge clk1);
        end
        n_tests++;
        if (s_bubble_cnt !== 4'd15 || s_stall_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL bubble_sat: bub=%0d stl=%0d, required 15/15", s_bubble_cnt, s_stall_cnt);
        end
        s_rst = 1'b1;
        @(posedge clk1); @(negedge clk1);
        s_rst = 1'b0;
        n_tests++;
        if (s_bubble_cnt !== 4'd0 || s_stall_cnt !== 4'd0 || s_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clear: bub=%0d stl=%0d valid=%b, required 0/0/0", s_bubble_cnt, s_stall_cnt, s_out_valid);
        end
    endtask

    task automatic test_width();
        logic [74:0] want;
        w_rst = 1'b0; w_in_valid = 1'b1;
        w_ra = 5'd31; w_rb = 5'($urandom); w_rd = 5'($urandom);
        w_imm = 16'h8001; w_m1 = 16'($urandom); w_m2 = 16'($urandom); w_ctrl = 9'h1FF;
        want = {1'b1, 5'd31, w_rb, w_rd, 16'h8001, w_m1, w_m2, 9'h1FF};
        @(posedge clk1); @(negedge clk1);
        n_tests++;
        if ({w_out_valid, w_ra_out, w_rb_out, w_rd_out, w_imm_out, w_m1_out, w_m2_out, w_ctrl_out} !== want) begin
            n_fail++;
            $display("FAIL wide_load: got %h, required %h",
                     {w_out_valid, w_ra_out, w_rb_out, w_rd_out, w_imm_out, w_m1_out, w_m2_out, w_ctrl_out}, want);
        end
        w_flush = 1'b1;
        @(posedge clk1); @(negedge clk1);
        w_flush = 1'b0;
        n_tests++;
        if ({w_out_valid, w_ra_out, w_rb_out, w_rd_out, w_imm_out, w_m1_out, w_m2_out, w_ctrl_out} !== 75'd0 ||
            w_bubble_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL wide_flush: ctrl=%h valid=%b bub=%0d, required 0/0/1", w_ctrl_out, w_out_valid, w_bubble_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        exp_fields = '0; exp_bub = 0; exp_stl = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        rand_fields();
        s_rst = 1'b1; s_stall = 1'b0; s_flush = 1'b0; s_in_valid = 1'b0;
        w_rst = 1'b1; w_stall = 1'b0; w_flush = 1'b0; w_in_valid = 1'b0;
        w_ra = '0; w_rb = '0; w_rd = '0; w_imm = '0; w_m1 = '0; w_m2 = '0; w_ctrl = '0;
        test_reset();
        test_stall_hold();
        test_flush_priority();
        test_idle_bubbles();
        test_reset_midstream();
        test_random();
        test_saturation();
        test_width();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
